// File: rtl/axis_pkg.sv
// Shared AXI-Stream types for the frame FIFO and its users.
package axis_pkg;

  localparam int unsigned AXIS_DATA_W = 8;

  // One stream beat as stored in the FIFO: end-of-frame marker above the data.
  typedef struct packed {
    logic                   last;
    logic [AXIS_DATA_W-1:0] data;
  } axis_beat_t;

endpackage

// File: rtl/axis_fifo_mem.sv
// DEPTH x WIDTH register-array storage: synchronous write, asynchronous read.
module axis_fifo_mem #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 9,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are never reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_frame_fifo.sv
// First-word-fall-through AXI-Stream FIFO that also tracks how many complete
// frames (stored beats with tlast set) it currently holds.
module axis_frame_fifo
  import axis_pkg::*;
#(
  parameter  int unsigned DATA_W = AXIS_DATA_W,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [CNT_W-1:0]  level,
  output logic [CNT_W-1:0]  frames,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W:0]   head;
  logic [DATA_W:0]   wr_beat;
  logic              full_c;
  logic              empty_c;
  logic              push;
  logic              pop;
  logic              push_last;
  logic              pop_last;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full_c  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty_c = (wr_ptr == rd_ptr);

  assign push      = s_axis_tvalid && !full_c;
  assign pop       = !empty_c && m_axis_tready;
  assign push_last = push && s_axis_tlast;
  assign pop_last  = pop && head[DATA_W];

  assign wr_beat = {s_axis_tlast, s_axis_tdata};

  axis_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_beat),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      frames <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      // A frame end entering and one leaving in the same cycle cancel out.
      case ({push_last, pop_last})
        2'b10:   frames <= frames + CNT_W'(1);
        2'b01:   frames <= frames - CNT_W'(1);
        default: frames <= frames;
      endcase
    end
  end

  // Pointer difference modulo 2*DEPTH is exactly the occupancy.
  assign level = CNT_W'(wr_ptr - rd_ptr);
  assign full  = full_c;
  assign empty = empty_c;

  assign s_axis_tready = !full_c;
  assign m_axis_tvalid = !empty_c;

  // Head is masked while empty so unreset storage never leaks onto the bus.
  assign m_axis_tdata = empty_c ? '0 : head[DATA_W-1:0];
  assign m_axis_tlast = empty_c ? 1'b0 : head[DATA_W];

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Directed bench for axis_frame_fifo: accepted beats feed a scoreboard queue
// that a negedge monitor drains and compares whenever the FIFO pops.
module tb_axis_frame_fifo;
  import axis_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       s_axis_tdata = '0;
  logic             s_axis_tvalid = 1'b0;
  logic             s_axis_tlast = 1'b0;
  logic             s_axis_tready;
  logic [7:0]       m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tready = 1'b0;
  logic [CNT_W-1:0] level;
  logic [CNT_W-1:0] frames;
  logic             full;
  logic             empty;

  int n_cmp = 0;
  int n_err = 0;
  int n_popped = 0;
  axis_beat_t exp_q[$];

  axis_frame_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .level         (level),
    .frames        (frames),
    .full          (full),
    .empty         (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard monitor: compare pops first, then record this edge's accepted beat.
  always @(negedge clk) begin : monitor
    axis_beat_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL pop_unexpected: got data 0x%0h with no beat expected", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", int'(m_axis_tdata), int'(e.data));
          chk("pop_last", int'(m_axis_tlast), int'(e.last));
          n_popped++;
        end
      end
      if (s_axis_tvalid && s_axis_tready) begin
        e.data = s_axis_tdata;
        e.last = s_axis_tlast;
        exp_q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat until accepted (bounded), then drop tvalid.
  task automatic push_beat(input logic [7:0] d, input logic l);
    logic ok;
    ok = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    for (int k = 0; k < 40 && !ok; k++) begin
      ok = s_axis_tready;
      step();
    end
    s_axis_tvalid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: beat 0x%0h not accepted, required within 40 cycles", d);
    end
  endtask

  task automatic drain(input string name, input int exp_pops);
    int base;
    base = n_popped;
    m_axis_tready = 1'b1;
    for (int k = 0; k < 60 && !empty; k++) step();
    m_axis_tready = 1'b0;
    chk({name, "_empty"}, int'(empty), 1);
    chk({name, "_pops"}, n_popped - base, exp_pops);
    chk({name, "_frames"}, int'(frames), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset held two cycles with tvalid high: nothing may be stored.
    rst = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 8'h55;
    #1;
    step();
    step();
    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_frames", int'(frames), 0);
    chk("rst_s_ready", int'(s_axis_tready), 1);
    chk("rst_m_valid", int'(m_axis_tvalid), 0);
    chk("rst_m_data", int'(m_axis_tdata), 0);
    chk("rst_m_last", int'(m_axis_tlast), 0);
    step();
    chk("rst_level_hold", int'(level), 0);

    // Single three-beat frame.
    push_beat(8'h03, 1'b0);
    chk("f1_valid_after_1", int'(m_axis_tvalid), 1);
    chk("f1_head_after_1", int'(m_axis_tdata), 8'h03);
    push_beat(8'h0A, 1'b0);
    push_beat(8'h0F, 1'b1);
    chk("f1_level", int'(level), 3);
    chk("f1_frames", int'(frames), 1);
    chk("f1_head_stable", int'(m_axis_tdata), 8'h03);
    chk("f1_head_last", int'(m_axis_tlast), 0);
    drain("f1", 3);

    // Fill to full: values 0..15, tlast on 7 and 15.
    for (int i = 0; i < 16; i++) push_beat(8'(i), (i == 7) || (i == 15));
    chk("full_flag", int'(full), 1);
    chk("full_s_ready", int'(s_axis_tready), 0);
    chk("full_level", int'(level), 16);
    chk("full_frames", int'(frames), 2);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h10;
    s_axis_tlast  = 1'b0;
    step();
    chk("full_held_level", int'(level), 16);
    m_axis_tready = 1'b1;
    step();
    m_axis_tready = 1'b0;
    chk("full_pop_level", int'(level), 15);
    chk("full_pop_s_ready", int'(s_axis_tready), 1);
    chk("full_pop_frames", int'(frames), 2);
    step();
    s_axis_tvalid = 1'b0;
    chk("full_17th_level", int'(level), 16);
    chk("full_17th_full", int'(full), 1);
    chk("full_17th_head", int'(m_axis_tdata), 1);
    drain("full", 16);

    // 40 beats streaming with the consumer always ready.
    m_axis_tready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push_beat(8'(8'h20 + i), (i % 8) == 7);
      chk("stream_level", int'(level), 1);
    end
    step();
    m_axis_tready = 1'b0;
    chk("stream_empty", int'(empty), 1);
    chk("stream_frames", int'(frames), 0);
    chk("stream_pops", n_popped, 3 + 17 + 40);

    // Frame end pushed while a frame end pops.
    push_beat(8'h41, 1'b1);
    push_beat(8'h42, 1'b0);
    push_beat(8'h43, 1'b0);
    push_beat(8'h44, 1'b0);
    chk("cc_level_pre", int'(level), 4);
    chk("cc_frames_pre", int'(frames), 1);
    chk("cc_head_last", int'(m_axis_tlast), 1);
    m_axis_tready = 1'b1;
    push_beat(8'h45, 1'b1);
    m_axis_tready = 1'b0;
    chk("cc_level", int'(level), 4);
    chk("cc_frames", int'(frames), 1);
    chk("cc_head", int'(m_axis_tdata), 8'h42);
    drain("cc", 4);

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 5; i++) push_beat(8'(8'h50 + i), 1'b0);
    chk("mid_level_pre", int'(level), 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_level", int'(level), 0);
    chk("mid_frames", int'(frames), 0);
    chk("mid_empty", int'(empty), 1);
    chk("mid_m_valid", int'(m_axis_tvalid), 0);
    chk("mid_m_data", int'(m_axis_tdata), 0);
    push_beat(8'h09, 1'b1);
    chk("mid_head", int'(m_axis_tdata), 8'h09);
    chk("mid_head_last", int'(m_axis_tlast), 1);
    chk("mid_frames_post", int'(frames), 1);
    drain("mid", 1);

    chk("scoreboard_leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_frame_fifo.md
Name: axis_frame_fifo

Overview:
- Synchronous AXI-Stream FIFO that sits directly downstream of the 8-bit stream source (newd/din in, dout/last out).
- Buffers data beats together with their tlast markers.
- Presents a standard AXI-Stream master toward the consumer.
- Reports buffer fill level and the number of complete frames held, so downstream logic can wait for a whole frame before draining.

Parameters:
- DATA_W, 8, width of tdata.
- DEPTH, 16, number of entries; must be a power of 2, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the level and frame-count outputs (derived; not overridden).

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- s_axis_tdata  input  DATA_W  write data beat.
- s_axis_tvalid  input  1  write beat valid.
- s_axis_tlast  input  1  write beat is the last beat of its frame.
- s_axis_tready  output  1  FIFO can accept a beat.
- m_axis_tdata  output  DATA_W  head-of-FIFO data.
- m_axis_tvalid  output  1  head entry valid.
- m_axis_tlast  output  1  head entry's tlast.
- m_axis_tready  input  1  consumer accepts head.
- level  output  CNT_W  entries currently stored, 0..DEPTH.
- frames  output  CNT_W  complete frames stored (count of stored entries with tlast=1).
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.

Behaviour:
- Reset: clk and rst are a single clock domain; reset is synchronous and active-high.
  - rst=1 at a rising edge clears write/read pointers, level and frames to 0.
  - Next cycle: empty=1, full=0, m_axis_tvalid=0, s_axis_tready=1, m_axis_tlast=0, m_axis_tdata=0.
  - Storage array contents are not reset.
  - Reset mid-frame discards all stored beats, including partial frames.
- Push: occurs when s_axis_tvalid && s_axis_tready.
  - Stores {tlast,tdata} at the write pointer.
  - Write pointer increments modulo 2*DEPTH (extra wrap bit).
- Pop: occurs when m_axis_tvalid && m_axis_tready.
  - Read pointer increments modulo 2*DEPTH.
- Status decode:
  - full when pointer low bits are equal and wrap bits differ.
  - empty when the pointers are fully equal.
- Handshake outputs:
  - s_axis_tready = !full.
  - m_axis_tvalid = !empty.
  - m_axis_tdata/m_axis_tlast = entry at the read pointer (first-word-fall-through, read combinationally from the array).
- Latency: a beat pushed at edge N is visible on m_axis at cycle N+1; minimum 1-cycle fall-through.
- Throughput: one push and one pop per cycle, sustained.
- Simultaneous push and pop:
  - level unchanged.
  - frames: +1 if pushed tlast only; -1 if popped tlast only; unchanged if both or neither.
- Boundaries:
  - Full: tready=0, so no push that cycle even if a pop occurs. tready rises the cycle after the pop.
  - Empty: tvalid=0, so no pop. A push while empty gives tvalid=1 the next cycle.
  - Pointer wrap past DEPTH-1 is seamless; data order is preserved.
- AXI rules:
  - m_axis_tdata/tlast are stable while m_axis_tvalid=1 and tready=0.
  - tvalid never depends combinationally on m_axis_tready.
- s_axis_tdata and s_axis_tlast are ignored when s_axis_tvalid=0.
- No overflow or underflow is possible via the handshake; there is no error output.

Decomposition:
- Package axis_pkg holds:
  - typedef axis_beat_t (packed struct {logic last; logic [DATA_W-1:0] data;}) with DATA_W default 8.
  - localparam AXIS_DATA_W = 8.
- One sub-module is natural: axis_fifo_mem, a DEPTH x (DATA_W+1) register-array RAM with synchronous write and asynchronous read.
- Pointer, level and frame logic stays in axis_frame_fifo.

Test Plan:
- Reset: hold rst=1 for 2 cycles with s_axis_tvalid=1 -> empty=1, level=0, frames=0, s_axis_tready=1, m_axis_tvalid=0; nothing is stored.
- Single frame: push 0x03,0x0A,0x0F(tlast) with m_axis_tready=0 -> level=3, frames=1. Then m_axis_tready=1 -> pops 0x03,0x0A,0x0F in order, m_axis_tlast=1 only on 0x0F; level=0, frames=0.
- Fill to full: DEPTH=16, push 16 beats (values 0..15, tlast on 7 and 15), no pops -> full=1, s_axis_tready=0, frames=2. A 17th beat is held off. One pop -> tready=1 the following cycle, and the 17th beat is accepted.
- Simultaneous traffic: stream 40 beats with both tvalid and tready=1 continuously after the first beat -> level stays at 1, output sequence equals input, and the pointers wrap twice without error.
- Frame count with concurrent tlast: at level=4, frames=1, push a beat with tlast=1 in the same cycle that the head with tlast=1 pops -> frames stays 1, level stays 4.
- Reset mid-frame: push 5 beats without tlast, assert rst for one cycle -> level=0, frames=0, empty=1. The next pushed beat 0x09 appears first on m_axis_tdata.
